cell_pos_reader: RTL and testbench
==================================

# cell_pos_reader

Read-side streaming engine for one position cell memory in the MD force-evaluation datapath. On `start` it reads the particle count from address 0, then reads addresses 1..count and presents each `{posz, posy, posx}` word as a valid/ready stream toward the force pipeline. The memory's 2-cycle read latency is absorbed by credit-based issue into a small output FIFO, so downstream backpressure never loses data.

## Interface
- `DATA_WIDTH`, 96: position word width, `{posz, posy, posx}`, 32 bits each.
- `ADDR_WIDTH`, 8: cell memory address width.
- `PARTICLE_NUM`, 220: memory depth. The maximum legal count is `PARTICLE_NUM-1`.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `start` input, 1 bit: one-cycle request to stream the cell. It is ignored while `busy` is high.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done` output, 1 bit: one-cycle pulse after the last particle handshake, or after a zero count.
- `particle_count` output, ADDR_WIDTH bits: count latched from address 0. It holds until the next `start`.
- `mem_addr` output, ADDR_WIDTH bits: address to the cell memory.
- `mem_rden` output, 1 bit: read enable to the cell memory.
- `mem_q` input, DATA_WIDTH bits: memory read data, valid 2 cycles after `mem_rden`.
- `out_valid` output, 1 bit: stream data valid.
- `out_ready` input, 1 bit: downstream accept.
- `out_data` output, DATA_WIDTH bits: position word.
- `out_pid` output, ADDR_WIDTH bits: particle address (1..count) of `out_data`.
- `out_last` output, 1 bit: high with the final particle of the cell.

## Operation
- The FSM has five states: IDLE, CNT_REQ, CNT_WAIT, STREAM, FIN.
- IDLE:
  - `start` moves the FSM to CNT_REQ.
  - `start` also clears the FIFO, the in-flight tracker and `particle_count`.
- CNT_REQ: drives `mem_rden`=1 and `mem_addr`=0 for one cycle, then moves to CNT_WAIT.
- CNT_WAIT: waits 2 cycles, then latches `mem_q[ADDR_WIDTH-1:0]` into `particle_count`.
  - If the count is 0, go to FIN.
  - Otherwise set `next_addr`=1 and go to STREAM.
- STREAM:
  - Issue a read at `next_addr` whenever `next_addr <= particle_count` and `fifo_count + inflight < 4`.
  - Increment `next_addr` on each issue.
  - A 2-stage valid/address shift register tracks in-flight reads.
  - When a read returns, push `{mem_q, addr}` into the 4-entry FIFO. The returning address equals `particle_count` exactly when that entry is the last particle.
  - Leave STREAM for FIN on the handshake (`out_valid && out_ready`) of the entry whose `out_last`=1.
- FIN: pulse `done` for one cycle and return to IDLE. `busy` drops in the same cycle.
- Output stream:
  - `out_valid` = FIFO not empty.
  - `out_data`, `out_pid` and `out_last` come from the FIFO head and are held stable while `out_valid && !out_ready`.
- Idle memory interface: `mem_rden`=0 and `mem_addr`=0 whenever no read is issued.
- Simultaneous push and pop in one cycle keeps `fifo_count` unchanged.
- The credit rule guarantees the FIFO never overflows. A push into a full FIFO is a design error; flag it with an assertion in simulation.

## Timing
- Reset values: `busy`=0, `done`=0, `particle_count`=0, `mem_addr`=0, `mem_rden`=0, `out_valid`=0, `out_data`=0, `out_pid`=0, `out_last`=0. The FSM resets to IDLE, and the FIFO and in-flight tracker are emptied.
- A read issued in cycle t has its data on `mem_q` in cycle t+2. The data is pushed at the t+2 edge and is visible on `out_*` in cycle t+3.
- Sequence from `start` in cycle 0:
  - Cycle 1: address 0 read (CNT_REQ).
  - Cycle 3: count captured.
  - Cycle 4: first particle read.
  - Cycle 7: first `out_valid`.
- With `out_ready` held high, one particle is output per cycle. N particles finish with `done` in cycle 7+N.
- `rst` asserted mid-operation: state is cleared immediately. In-flight reads are discarded and their returning data is not pushed.
- A `start` that coincides with `done` is ignored; it is accepted only in IDLE.

## Configuration
- `CELL_READER_CLAMP_EN` defined: a count above `PARTICLE_NUM-1` is clamped to `PARTICLE_NUM-1` before latching, so the reader never addresses past the memory.
- `CELL_READER_CLAMP_EN` undefined: the raw count is latched and used unchanged.

## Test plan
- Count 5, `out_ready`=1: `out_pid` 1..5 in cycles 7..11, `out_last` only on pid 5, `done` in cycle 12, `out_data` matches memory.
- Count 0: no `out_valid`, `done` in cycle 4, `particle_count`=0.
- Count 10, `out_ready` toggling 1/0 and stalled for 6 cycles:
  - no loss or duplication of words;
  - at most 4 words buffered;
  - `out_data` stable while stalled.
- Count 219 with full random backpressure: all 219 words in order, a single `done`.
- `rst` pulsed in cycle 9 of a count-20 stream: all outputs return to 0 next cycle. A fresh `start` then streams pid 1..20 correctly.
- Count word 250:
  - with `CELL_READER_CLAMP_EN`, `particle_count`=219 and the highest address is 219;
  - without it, `particle_count`=250.

Source files
------------

// File: rtl/cell_pos_reader.sv
// rtl/cell_pos_reader.sv - streams {posz,posy,posx} words of one position cell memory; CELL_READER_CLAMP_EN clamps the count
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rden,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_pid,
  output logic                  out_last
);

  typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, FIN} state_t;

  state_t                state_q, state_d;
  logic                  wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  // one bit wider so the issue pointer can step past a count of 2**ADDR_WIDTH-1
  logic [ADDR_WIDTH:0]   next_addr_q, next_addr_d;
  logic [1:0]            inf_vld_q, inf_vld_d;
  logic [ADDR_WIDTH-1:0] inf_addr_q [2];
  logic [ADDR_WIDTH-1:0] inf_addr_d [2];
  logic [DATA_WIDTH-1:0] fifo_data_q [4];
  logic [DATA_WIDTH-1:0] fifo_data_d [4];
  logic [ADDR_WIDTH-1:0] fifo_pid_q [4];
  logic [ADDR_WIDTH-1:0] fifo_pid_d [4];
  logic [3:0]            fifo_last_q, fifo_last_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]            fifo_count_q, fifo_count_d;
  logic [2:0]            inflight;
  logic                  issue, push, pop, clear;
  logic [ADDR_WIDTH-1:0] count_in;

  // count word as it will be latched (optionally limited to the memory depth)
`ifdef CELL_READER_CLAMP_EN
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  assign count_in = (mem_q[ADDR_WIDTH-1:0] > MAX_COUNT) ? MAX_COUNT : mem_q[ADDR_WIDTH-1:0];
`else
  assign count_in = mem_q[ADDR_WIDTH-1:0];
`endif

  // stream side: head of the FIFO, zeroed while empty
  always_comb begin
    out_valid = (fifo_count_q != 3'd0);
    out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_pid   = out_valid ? fifo_pid_q[rd_ptr_q] : '0;
    out_last  = out_valid & fifo_last_q[rd_ptr_q];
    pop       = out_valid & out_ready;
    push      = inf_vld_q[1];
    inflight  = {2'b00, inf_vld_q[0]} + {2'b00, inf_vld_q[1]};
  end

  // FSM next state, memory requests and credit-gated issue
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    count_d     = count_q;
    next_addr_d = next_addr_q;
    issue       = 1'b0;
    clear       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rden    = 1'b0;
    mem_addr    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CNT_REQ;
          count_d = '0;
          clear   = 1'b1;
        end
      end
      CNT_REQ: begin
        busy     = 1'b1;
        mem_rden = 1'b1;
        wait_d   = 1'b0;
        state_d  = CNT_WAIT;
      end
      CNT_WAIT: begin
        busy   = 1'b1;
        wait_d = 1'b1;
        if (wait_q) begin
          wait_d  = 1'b0;
          count_d = count_in;
          if (count_in == '0) begin
            state_d = FIN;
          end else begin
            next_addr_d = (ADDR_WIDTH+1)'(1);
            state_d     = STREAM;
          end
        end
      end
      STREAM: begin
        busy = 1'b1;
        // FIFO entries plus reads still in the memory pipe never exceed 4
        if ((next_addr_q <= {1'b0, count_q}) && ((fifo_count_q + inflight) < 3'd4)) begin
          issue       = 1'b1;
          mem_rden    = 1'b1;
          mem_addr    = next_addr_q[ADDR_WIDTH-1:0];
          next_addr_d = next_addr_q + 1'b1;
        end
        if (pop && out_last) begin
          state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // in-flight tracker and 4-entry output FIFO
  always_comb begin
    inf_vld_d     = {inf_vld_q[0], issue};
    inf_addr_d[0] = mem_addr;
    inf_addr_d[1] = inf_addr_q[0];
    fifo_data_d   = fifo_data_q;
    fifo_pid_d    = fifo_pid_q;
    fifo_last_d   = fifo_last_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_count_d  = fifo_count_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = mem_q;
      fifo_pid_d[wr_ptr_q]  = inf_addr_q[1];
      fifo_last_d[wr_ptr_q] = (inf_addr_q[1] == count_q);
      wr_ptr_d              = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 3'd1;
      2'b01:   fifo_count_d = fifo_count_q - 3'd1;
      default: fifo_count_d = fifo_count_q;
    endcase
    if (clear) begin
      inf_vld_d    = '0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      fifo_count_d = '0;
    end
  end

  // state registers; reset drops in-flight reads so their data is never pushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wait_q       <= 1'b0;
      count_q      <= '0;
      next_addr_q  <= '0;
      inf_vld_q    <= '0;
      fifo_last_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < 2; i++) inf_addr_q[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pid_q[i]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      count_q      <= count_d;
      next_addr_q  <= next_addr_d;
      inf_vld_q    <= inf_vld_d;
      inf_addr_q   <= inf_addr_d;
      fifo_data_q  <= fifo_data_d;
      fifo_pid_q   <= fifo_pid_d;
      fifo_last_q  <= fifo_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  assign particle_count = count_q;

  // a return landing in a full FIFO means the credit accounting is broken
  assert property (@(posedge clk) disable iff (rst) !(push && (fifo_count_q == 3'd4)));

endmodule

// File: tb/tb_cell_pos_reader.sv
// tb/tb_cell_pos_reader.sv - randomized scoreboard bench for cell_pos_reader
module tb_cell_pos_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  particle_count;
  logic [7:0]  mem_addr;
  logic        mem_rden;
  logic [95:0] mem_q;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [7:0]  out_pid;
  logic        out_last;

  always #5 clk = ~clk;

  cell_pos_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .particle_count(particle_count), .mem_addr(mem_addr), .mem_rden(mem_rden),
    .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_pid(out_pid), .out_last(out_last)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;
  int rmode = 0;
  bit timing = 1'b0;
  bit mon_en = 1'b0;
  int cur_eff = 0;
  int done_cnt = 0, done_rel = -1, first_v = -1, max_addr = 0;
  int rd_total = 0, rd_h1 = 0, rd_h2 = 0, acc_total = 0;
  bit prev_stall = 1'b0;
  logic [95:0] prev_data;
  logic [7:0]  prev_pid;
  int          exp_pid[$];
  logic [95:0] exp_data[$];

  // cell memory with a 2-cycle read pipe
  logic [95:0] mem [256];
  logic [95:0] q1;
  always @(posedge clk) begin
    q1    <= mem_rden ? mem[mem_addr] : '0;
    mem_q <= q1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // downstream ready: 0 = always, 1 = toggling with a 6-cycle stall, 2 = random
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          int rel;
          rel = cyc - t0;
          out_ready = (rel >= 12 && rel < 18) ? 1'b0 : rel[0];
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard: expected words, occupancy from observed reads, stall stability, timing
  always @(negedge clk) begin
    int rel;
    int buffered;
    rel = cyc - t0;
    if (rst) begin
      rd_total = 0; rd_h1 = 0; rd_h2 = 0; acc_total = 0; prev_stall = 1'b0;
    end else if (mon_en) begin
      buffered = rd_h2 - acc_total;
      chk("occ_valid", out_valid, buffered > 0);
      chk("occ_le4", buffered <= 4, 1);
      rd_h2 = rd_h1;
      rd_h1 = rd_total;
      if (mem_rden && mem_addr != 8'd0) begin
        rd_total++;
        if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
      end
      if (prev_stall) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_pid", out_pid, prev_pid);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_pid   = out_pid;
      if (out_valid && first_v < 0) first_v = rel;
      if (out_valid && out_ready) begin
        acc_total++;
        if (exp_pid.size() == 0) begin
          chk("unexpected_word", out_valid, 0);
        end else begin
          int p;
          p = exp_pid.pop_front();
          chk("pid", out_pid, p);
          chk("data", out_data, exp_data.pop_front());
          chk("last", out_last, exp_pid.size() == 0);
          if (timing) chk("hs_cycle", rel, 6 + p);
        end
      end
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
    end
  end

  task automatic begin_cell(input int cw, input int mode, input bit tm);
    logic [95:0] w;
    int eff;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    w = mem[0];
    w[7:0] = 8'(cw);
    mem[0] = w;
    eff = cw;
`ifdef CELL_READER_CLAMP_EN
    if (eff > 219) eff = 219;
`endif
    exp_pid.delete();
    exp_data.delete();
    for (int p = 1; p <= eff; p++) begin
      exp_pid.push_back(p);
      exp_data.push_back(mem[p]);
    end
    cur_eff = eff;
    done_cnt = 0; done_rel = -1; first_v = -1; max_addr = 0;
    rd_total = 0; rd_h1 = 0; rd_h2 = 0; acc_total = 0; prev_stall = 1'b0;
    @(posedge clk); #1;
    rmode = mode; timing = tm; start = 1'b1; t0 = cyc; mon_en = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic finish_cell();
    int budget;
    budget = 0;
    while (done_cnt == 0 && budget < 3000) begin
      @(posedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("words_left", exp_pid.size(), 0);
    chk("particle_count", particle_count, cur_eff);
    chk("max_addr", max_addr, cur_eff);
    chk("busy_idle", busy, 0);
    if (timing) begin
      chk("done_cycle", done_rel, (cur_eff == 0) ? 4 : 7 + cur_eff);
      chk("first_valid", first_v, (cur_eff == 0) ? -1 : 7);
    end
    mon_en = 1'b0;
    rmode = 0;
  endtask

  task automatic chk_quiet_outputs();
    chk("q_busy", busy, 0);
    chk("q_done", done, 0);
    chk("q_particle_count", particle_count, 0);
    chk("q_mem_addr", mem_addr, 0);
    chk("q_mem_rden", mem_rden, 0);
    chk("q_out_valid", out_valid, 0);
    chk("q_out_data", out_data, 0);
    chk("q_out_pid", out_pid, 0);
    chk("q_out_last", out_last, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    begin_cell(5, 0, 1'b1);
    finish_cell();

    begin_cell(0, 0, 1'b1);
    finish_cell();

    begin_cell(10, 1, 1'b0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_cell();

    begin_cell(219, 2, 1'b0);
    finish_cell();

    begin_cell(20, 0, 1'b1);
    while (cyc - t0 < 9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_quiet_outputs();

    begin_cell(20, 0, 1'b1);
    finish_cell();

    begin_cell(250, 0, 1'b1);
    finish_cell();

    for (int k = 0; k < 3; k++) begin
      begin_cell(int'($urandom_range(1, 40)), 2, 1'b0);
      finish_cell();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
